ahf_mcport_v: RTL and testbench

Parametrised multi-channel inter-core message port for the 14-bit RISC521 cores, successor to the fixed three-channel Read/Write/Done I/O in the core's 0x3F page. Presents a memory-mapped CPU interface: page offsets 0x80–0xFF, with the core decoding page 0x3F. Provides NCH independent channels, each with a TX FIFO and an RX FIFO and a 4-phase req/ack link to a peer core on the same clock. Adds blocking/non-blocking access, per-channel status, flush and an RX interrupt.

---
 rtl/ahf_mcport_pkg.sv | 19 +
 rtl/ahf_sync_fifo_v.sv | 53 +++++
 rtl/ahf_mcport_v.sv | 159 +++++++++++++++
 tb/tb_ahf_mcport_v.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahf_mcport_pkg.sv
// Shared constants and state types for the ahf_mcport_v inter-core message port.
package ahf_mcport_pkg;

  localparam logic [7:0] OFS_DATA = 8'h80;
  localparam logic [7:0] OFS_STAT = 8'hC0;
  localparam logic [7:0] OFS_CTRL = 8'hE0;

  localparam int unsigned ST_RX_EMPTY = 0;
  localparam int unsigned ST_RX_FULL  = 1;
  localparam int unsigned ST_TX_EMPTY = 2;
  localparam int unsigned ST_TX_FULL  = 3;
  localparam int unsigned ST_TX_BUSY  = 4;
  localparam int unsigned ST_ERR      = 5;
  localparam int unsigned ST_RX_COUNT = 6;

  typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_REL} tx_state_e;
  typedef enum logic {RX_IDLE, RX_ACK} rx_state_e;

endpackage

// File: rtl/ahf_sync_fifo_v.sv
// Synchronous FIFO with occupancy count and flush; full/empty come from registered state only.
module ahf_sync_fifo_v #(
  parameter int unsigned W     = 14,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [W-1:0]  o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          w_do_push, w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rptr];
  assign w_do_pop  = i_pop & ~o_empty;
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule

// File: rtl/ahf_mcport_v.sv
// Multi-channel message port: CPU-mapped TX/RX FIFOs per channel with 4-phase peer links.
module ahf_mcport_v
  import ahf_mcport_pkg::*;
#(
  parameter int unsigned NCH      = 3,
  parameter int unsigned W        = 14,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned BLOCKING = 1
) (
  input  logic             Clk_pin0,
  input  logic             Reset_pin,
  input  logic [7:0]       cpu_addr,
  input  logic             cpu_rd,
  input  logic             cpu_wr,
  input  logic [W-1:0]     cpu_wdata,
  output logic [W-1:0]     cpu_rdata,
  output logic             cpu_stall,
  output logic [NCH*W-1:0] tx_data,
  output logic [NCH-1:0]   tx_req,
  input  logic [NCH-1:0]   tx_ack,
  input  logic [NCH*W-1:0] rx_data,
  input  logic [NCH-1:0]   rx_req,
  output logic [NCH-1:0]   rx_ack,
  output logic             irq
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [NCH-1:0] w_data_sel, w_stat_sel, w_ctrl_sel;
  logic [NCH-1:0] w_rx_empty, w_rx_full, w_tx_empty, w_tx_full, w_tx_busy;
  logic [NCH-1:0] w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_flush, w_rx_ie;
  logic [W-1:0]   w_rx_head [NCH];
  logic [W-1:0]   w_tx_head [NCH];
  logic [W-1:0]   w_status  [NCH];
  logic [W-1:0]   r_rdata, w_rdata_d;
  logic           w_wr, w_rd, w_stall_cond, w_stall;

  assign w_wr = cpu_wr;
  assign w_rd = cpu_rd & ~cpu_wr;

  assign w_stall_cond = (w_rd & |(w_data_sel & w_rx_empty)) | (w_wr & |(w_data_sel & w_tx_full));
  assign w_stall      = (BLOCKING != 0) ? w_stall_cond : 1'b0;
  assign cpu_stall    = w_stall;
  assign cpu_rdata    = r_rdata;
  assign irq          = |(w_rx_ie & ~w_rx_empty);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    tx_state_e     r_tx_st, w_tx_st_d;
    rx_state_e     r_rx_st, w_rx_st_d;
    logic [W-1:0]  r_tx_data, w_stat;
    logic [CW-1:0] w_rx_count, w_unused_tx_count;
    logic          r_rx_ie, r_err, w_pop, w_push, w_err_set, w_err_clr;

    assign w_data_sel[c] = (cpu_addr == OFS_DATA + 8'(c));
    assign w_stat_sel[c] = (cpu_addr == OFS_STAT + 8'(c));
    assign w_ctrl_sel[c] = (cpu_addr == OFS_CTRL + 8'(c));

    assign w_tx_push[c] = w_wr & w_data_sel[c] & ~w_tx_full[c];
    assign w_rx_pop[c]  = w_rd & w_data_sel[c] & ~w_rx_empty[c];
    assign w_flush[c]   = w_wr & w_ctrl_sel[c] & cpu_wdata[1];
    assign w_err_set    = (BLOCKING == 0) & w_data_sel[c] &
                          ((w_wr & w_tx_full[c]) | (w_rd & w_rx_empty[c]));
    assign w_err_clr    = w_rd & w_stat_sel[c];

    ahf_sync_fifo_v #(.W(W), .DEPTH(DEPTH)) u_tx_fifo (
      .i_clk(Clk_pin0), .i_rst_n(Reset_pin), .i_flush(w_flush[c]),
      .i_push(w_tx_push[c]), .i_wdata(cpu_wdata), .i_pop(w_tx_pop[c]),
      .o_rdata(w_tx_head[c]), .o_full(w_tx_full[c]), .o_empty(w_tx_empty[c]),
      .o_count(w_unused_tx_count)
    );

    ahf_sync_fifo_v #(.W(W), .DEPTH(DEPTH)) u_rx_fifo (
      .i_clk(Clk_pin0), .i_rst_n(Reset_pin), .i_flush(w_flush[c]),
      .i_push(w_rx_push[c]), .i_wdata(rx_data[c*W +: W]), .i_pop(w_rx_pop[c]),
      .o_rdata(w_rx_head[c]), .o_full(w_rx_full[c]), .o_empty(w_rx_empty[c]),
      .o_count(w_rx_count)
    );

    always_comb begin
      w_tx_st_d = r_tx_st;
      w_pop     = 1'b0;
      unique case (r_tx_st)
        TX_IDLE: if (!w_tx_empty[c]) begin
          w_tx_st_d = TX_REQ;
          w_pop     = 1'b1;
        end
        TX_REQ:  if (tx_ack[c])  w_tx_st_d = TX_REL;
        TX_REL:  if (!tx_ack[c]) w_tx_st_d = TX_IDLE;
        default: w_tx_st_d = TX_IDLE;
      endcase
    end

    always_comb begin
      w_rx_st_d = r_rx_st;
      w_push    = 1'b0;
      unique case (r_rx_st)
        RX_IDLE: if (rx_req[c] && !w_rx_full[c]) begin
          w_rx_st_d = RX_ACK;
          w_push    = 1'b1;
        end
        RX_ACK:  if (!rx_req[c]) w_rx_st_d = RX_IDLE;
        default: w_rx_st_d = RX_IDLE;
      endcase
    end

    always_ff @(posedge Clk_pin0 or negedge Reset_pin) begin
      if (!Reset_pin) begin
        r_tx_st   <= TX_IDLE;
        r_rx_st   <= RX_IDLE;
        r_tx_data <= '0;
        r_rx_ie   <= 1'b0;
        r_err     <= 1'b0;
      end else begin
        r_tx_st <= w_tx_st_d;
        r_rx_st <= w_rx_st_d;
        if (w_pop) r_tx_data <= w_tx_head[c];
        if (w_wr && w_ctrl_sel[c]) r_rx_ie <= cpu_wdata[0];
        if (w_flush[c] || w_err_clr) r_err <= 1'b0;
        else if (w_err_set)          r_err <= 1'b1;
      end
    end

    always_comb begin
      w_stat                        = '0;
      w_stat[ST_RX_EMPTY]           = w_rx_empty[c];
      w_stat[ST_RX_FULL]            = w_rx_full[c];
      w_stat[ST_TX_EMPTY]           = w_tx_empty[c];
      w_stat[ST_TX_FULL]            = w_tx_full[c];
      w_stat[ST_TX_BUSY]            = w_tx_busy[c];
      w_stat[ST_ERR]                = r_err;
      w_stat[ST_RX_COUNT +: CW]     = w_rx_count;
    end

    assign w_status[c]       = w_stat;
    assign w_tx_pop[c]       = w_pop;
    assign w_rx_push[c]      = w_push;
    assign w_rx_ie[c]        = r_rx_ie;
    assign w_tx_busy[c]      = (r_tx_st != TX_IDLE);
    assign tx_req[c]         = (r_tx_st == TX_REQ);
    assign rx_ack[c]         = (r_rx_st == RX_ACK);
    assign tx_data[c*W +: W] = r_tx_data;
  end

  always_comb begin
    w_rdata_d = '0;
    for (int c = 0; c < NCH; c++) begin
      if (w_data_sel[c]) w_rdata_d = w_rx_empty[c] ? '0 : w_rx_head[c];
      if (w_stat_sel[c]) w_rdata_d = w_status[c];
      if (w_ctrl_sel[c]) w_rdata_d = W'(w_rx_ie[c]);
    end
  end

  // A stalled read leaves the previous data in place until it completes.
  always_ff @(posedge Clk_pin0 or negedge Reset_pin) begin
    if (!Reset_pin)            r_rdata <= '0;
    else if (w_rd && !w_stall) r_rdata <= w_rdata_d;
  end

endmodule

// File: tb/tb_ahf_mcport_v.sv
// Directed bench: one blocking and one non-blocking instance of ahf_mcport_v, 3 channels.
module tb_ahf_mcport_v;

  logic        clk, rst_n;
  logic [7:0]  addr, n_addr;
  logic        rd, wr, n_rd, n_wr;
  logic [13:0] wdata, n_wdata, rdata, n_rdata;
  logic        stall, n_stall, irq, n_irq;
  logic [41:0] tx_data, n_tx_data, rx_data, n_rx_data;
  logic [2:0]  tx_req, tx_ack, rx_req, rx_ack;
  logic [2:0]  n_tx_req, n_tx_ack, n_rx_req, n_rx_ack;
  int          checks, fails;
  logic [13:0] d;

  ahf_mcport_v #(.NCH(3), .W(14), .DEPTH(4), .BLOCKING(1)) u_dut (
    .Clk_pin0(clk), .Reset_pin(rst_n), .cpu_addr(addr), .cpu_rd(rd), .cpu_wr(wr),
    .cpu_wdata(wdata), .cpu_rdata(rdata), .cpu_stall(stall), .tx_data(tx_data),
    .tx_req(tx_req), .tx_ack(tx_ack), .rx_data(rx_data), .rx_req(rx_req),
    .rx_ack(rx_ack), .irq(irq)
  );

  ahf_mcport_v #(.NCH(3), .W(14), .DEPTH(4), .BLOCKING(0)) u_dut_nb (
    .Clk_pin0(clk), .Reset_pin(rst_n), .cpu_addr(n_addr), .cpu_rd(n_rd), .cpu_wr(n_wr),
    .cpu_wdata(n_wdata), .cpu_rdata(n_rdata), .cpu_stall(n_stall), .tx_data(n_tx_data),
    .tx_req(n_tx_req), .tx_ack(n_tx_ack), .rx_data(n_rx_data), .rx_req(n_rx_req),
    .rx_ack(n_rx_ack), .irq(n_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [13:0] v);
    addr = a; wdata = v; wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] a, output logic [13:0] v);
    addr = a; rd = 1'b1;
    tick();
    rd = 1'b0;
    v = rdata;
  endtask

  task automatic nb_write(input logic [7:0] a, input logic [13:0] v);
    n_addr = a; n_wdata = v; n_wr = 1'b1;
    tick();
    n_wr = 1'b0;
  endtask

  task automatic nb_read(input logic [7:0] a, output logic [13:0] v);
    n_addr = a; n_rd = 1'b1;
    tick();
    n_rd = 1'b0;
    v = n_rdata;
  endtask

  task automatic rx_send(input int ch, input logic [13:0] v);
    int n;
    rx_data[ch*14 +: 14] = v;
    rx_req[ch] = 1'b1;
    n = 0;
    while (!rx_ack[ch] && n < 8) begin tick(); n++; end
    checks++;
    if (rx_ack[ch] !== 1'b1) begin
      fails++;
      $display("FAIL rx_send_ack ch%0d got=%b want=1", ch, rx_ack[ch]);
    end
    rx_req[ch] = 1'b0;
    n = 0;
    while (rx_ack[ch] && n < 8) begin tick(); n++; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    addr = '0; rd = 0; wr = 0; wdata = '0; tx_ack = '0; rx_req = '0; rx_data = '0;
    n_addr = '0; n_rd = 0; n_wr = 0; n_wdata = '0; n_tx_ack = '0; n_rx_req = '0; n_rx_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rdata, stall, tx_data, tx_req, rx_ack, irq} !== 64'd0) begin
      fails++;
      $display("FAIL reset_outputs got=%h want=0", {rdata, stall, tx_data, tx_req, rx_ack, irq});
    end
    rst_n = 1'b1;
    tick();
    cpu_read(8'hC0, d);
    checks++; if (d !== 14'h0005) begin fails++; $display("FAIL reset_stat0 got=%h want=0005", d); end
    cpu_read(8'hC2, d);
    checks++; if (d !== 14'h0005) begin fails++; $display("FAIL reset_stat2 got=%h want=0005", d); end
    cpu_read(8'hC3, d);
    checks++; if (d !== 14'h0000) begin fails++; $display("FAIL unmapped_stat3 got=%h want=0000", d); end
    addr = 8'hA0; rd = 1'b1; #1;
    checks++; if (stall !== 1'b0) begin fails++; $display("FAIL unmapped_stall got=%b want=0", stall); end
    cpu_read(8'hA0, d);
    checks++; if (d !== 14'h0000) begin fails++; $display("FAIL unmapped_data got=%h want=0000", d); end
  endtask

  task automatic test_tx();
    cpu_write(8'h81, 14'h1234);
    checks++; if (tx_req !== 3'b000) begin fails++; $display("FAIL tx_req_early got=%b want=000", tx_req); end
    tick();
    checks++; if (tx_req !== 3'b010) begin fails++; $display("FAIL tx_req_rise got=%b want=010", tx_req); end
    checks++;
    if (tx_data[27:14] !== 14'h1234) begin
      fails++; $display("FAIL tx_data1 got=%h want=1234", tx_data[27:14]);
    end
    cpu_read(8'hC1, d);
    checks++; if (d !== 14'h0015) begin fails++; $display("FAIL tx_busy_stat got=%h want=0015", d); end
    tick();
    tx_ack[1] = 1'b1;
    tick();
    checks++; if (tx_req !== 3'b000) begin fails++; $display("FAIL tx_req_drop got=%b want=000", tx_req); end
    tx_ack[1] = 1'b0;
    tick();
    cpu_read(8'hC1, d);
    checks++; if (d !== 14'h0005) begin fails++; $display("FAIL tx_idle_stat got=%h want=0005", d); end
  endtask

  task automatic test_rx_full();
    for (int i = 1; i <= 4; i++) rx_send(2, 14'(i * 14'h0101));
    cpu_read(8'hC2, d);
    checks++; if (d !== 14'h0106) begin fails++; $display("FAIL rx_full_stat got=%h want=0106", d); end
    rx_data[41:28] = 14'h0505;
    rx_req[2] = 1'b1;
    repeat (3) tick();
    checks++; if (rx_ack[2] !== 1'b0) begin fails++; $display("FAIL rx_hold got=%b want=0", rx_ack[2]); end
    cpu_read(8'h82, d);
    checks++; if (d !== 14'h0101) begin fails++; $display("FAIL rx_word1 got=%h want=0101", d); end
    tick();
    checks++; if (rx_ack[2] !== 1'b1) begin fails++; $display("FAIL rx_5th_ack got=%b want=1", rx_ack[2]); end
    rx_req[2] = 1'b0;
    tick();
    for (int i = 2; i <= 5; i++) begin
      cpu_read(8'h82, d);
      checks++;
      if (d !== 14'(i * 14'h0101)) begin
        fails++; $display("FAIL rx_word%0d got=%h want=%h", i, d, 14'(i * 14'h0101));
      end
    end
    cpu_read(8'hC2, d);
    checks++; if (d !== 14'h0005) begin fails++; $display("FAIL rx_drained got=%h want=0005", d); end
  endtask

  task automatic test_stall();
    addr = 8'h80; rd = 1'b1; #1;
    checks++; if (stall !== 1'b1) begin fails++; $display("FAIL stall_rise got=%b want=1", stall); end
    repeat (2) tick();
    checks++; if (stall !== 1'b1) begin fails++; $display("FAIL stall_hold got=%b want=1", stall); end
    rx_data[13:0] = 14'h0ABC;
    rx_req[0] = 1'b1;
    tick();
    checks++; if (stall !== 1'b0) begin fails++; $display("FAIL stall_clear got=%b want=0", stall); end
    tick();
    rd = 1'b0;
    checks++; if (rdata !== 14'h0ABC) begin fails++; $display("FAIL stall_rdata got=%h want=0abc", rdata); end
    rx_req[0] = 1'b0;
    tick();
  endtask

  task automatic test_nonblocking();
    n_addr = 8'h80; n_rd = 1'b1; #1;
    checks++; if (n_stall !== 1'b0) begin fails++; $display("FAIL nb_stall got=%b want=0", n_stall); end
    nb_read(8'h80, d);
    checks++; if (d !== 14'h0000) begin fails++; $display("FAIL nb_empty_read got=%h want=0000", d); end
    nb_read(8'hC0, d);
    checks++; if (d !== 14'h0025) begin fails++; $display("FAIL nb_err_set got=%h want=0025", d); end
    nb_read(8'hC0, d);
    checks++; if (d !== 14'h0005) begin fails++; $display("FAIL nb_err_clr got=%h want=0005", d); end
    for (int i = 1; i <= 5; i++) nb_write(8'h80, 14'(14'h0010 + i));
    n_addr = 8'h80; n_wdata = 14'h0016; n_wr = 1'b1; #1;
    checks++; if (n_stall !== 1'b0) begin fails++; $display("FAIL nb_full_stall got=%b want=0", n_stall); end
    tick();
    n_wr = 1'b0;
    nb_read(8'hC0, d);
    checks++; if (d !== 14'h0039) begin fails++; $display("FAIL nb_tx_drop got=%h want=0039", d); end
    checks++;
    if (n_tx_data[13:0] !== 14'h0011) begin
      fails++; $display("FAIL nb_tx_head got=%h want=0011", n_tx_data[13:0]);
    end
  endtask

  task automatic test_irq();
    cpu_write(8'hE0, 14'h0001);
    checks++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_idle got=%b want=0", irq); end
    cpu_read(8'hE0, d);
    checks++; if (d !== 14'h0001) begin fails++; $display("FAIL ctrl_read got=%h want=0001", d); end
    rx_data[13:0] = 14'h0777;
    rx_req[0] = 1'b1;
    tick();
    checks++; if (irq !== 1'b1) begin fails++; $display("FAIL irq_rise got=%b want=1", irq); end
    rx_req[0] = 1'b0;
    tick();
    cpu_read(8'h80, d);
    checks++; if (d !== 14'h0777) begin fails++; $display("FAIL irq_word got=%h want=0777", d); end
    checks++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_fall got=%b want=0", irq); end
    cpu_write(8'hE0, 14'h0000);
  endtask

  task automatic test_flush();
    for (int i = 1; i <= 4; i++) cpu_write(8'h81, 14'(i * 14'h0011));
    cpu_write(8'hE1, 14'h0002);
    checks++; if (tx_req !== 3'b010) begin fails++; $display("FAIL flush_req got=%b want=010", tx_req); end
    checks++;
    if (tx_data[27:14] !== 14'h0011) begin
      fails++; $display("FAIL flush_inflight got=%h want=0011", tx_data[27:14]);
    end
    cpu_read(8'hC1, d);
    checks++; if (d !== 14'h0015) begin fails++; $display("FAIL flush_stat got=%h want=0015", d); end
    tx_ack[1] = 1'b1;
    tick();
    tx_ack[1] = 1'b0;
    repeat (4) tick();
    checks++; if (tx_req !== 3'b000) begin fails++; $display("FAIL flush_no_req got=%b want=000", tx_req); end
    cpu_read(8'hE1, d);
    checks++; if (d !== 14'h0000) begin fails++; $display("FAIL flush_ctrl got=%h want=0000", d); end
  endtask

  task automatic test_reset_mid();
    rx_data[13:0] = 14'h0042;
    rx_req[1] = 1'b1;
    cpu_write(8'h82, 14'h0055);
    tick();
    checks++;
    if ({rx_ack, tx_req} !== 6'b010_100) begin
      fails++; $display("FAIL mid_handshake got=%b want=010100", {rx_ack, tx_req});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rx_ack, tx_req} !== 6'b000_000) begin
      fails++; $display("FAIL mid_reset got=%b want=000000", {rx_ack, tx_req});
    end
    rx_req[1] = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    cpu_read(8'hC1, d);
    checks++; if (d !== 14'h0005) begin fails++; $display("FAIL mid_rx_lost got=%h want=0005", d); end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_tx();
    test_rx_full();
    test_stall();
    test_nonblocking();
    test_irq();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
